mso_capture: RTL and testbench

- Trigger-and-capture stage directly downstream of the decimation filter in the MSO acquisition path.
- Consumes the decimated 12-bit sample stream and stores it in a circular buffer with a programmable pre-trigger depth.
- Detects a level/slope trigger or a forced trigger, fills the remaining post-trigger samples, then freezes.
- Exposes the frozen record to the readout path in trigger-relative order.

---
 rtl/mso_pkg.sv | 17 +
 rtl/capture_ram.sv | 22 ++
 rtl/mso_capture.sv | 153 +++++++++++++++
 tb/tb_mso_capture.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mso_pkg.sv
// rtl/mso_pkg.sv - shared types and constants for the MSO trigger/capture stage
package mso_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } capture_state_t;

    localparam logic SLOPE_RISING  = 1'b0;
    localparam logic SLOPE_FALLING = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 12;

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - simple dual-port sample buffer, registered read, no reset
module capture_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/mso_capture.sv
// rtl/mso_capture.sv - pre/post-trigger circular capture with level/slope/forced trigger
module mso_capture
    import mso_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  force_trig,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_slope,
    input  logic [ADDR_WIDTH-1:0] pretrig,
    output logic [2:0]            state,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_A = '1;
    localparam logic [ADDR_WIDTH:0]   ONE_P = 1;

    capture_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr, cnt, pretrig_l;
    logic [ADDR_WIDTH:0]   post_cnt;
    logic [DATA_WIDTH-1:0] prev_data, ram_q;
    logic                  prev_valid, rd_loaded;
    logic                  wr_en, accept, level_hit, rd_fire, arm_go;

    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        accept    = 1'b0;
        level_hit = 1'b0;
        arm_go    = 1'b0;
        if (in_valid && prev_valid) begin
            if (trig_slope == SLOPE_RISING)
                level_hit = (prev_data < trig_level) && (in_data >= trig_level);
            else
                level_hit = (prev_data >= trig_level) && (in_data < trig_level);
        end
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                arm_go = arm;
                if (arm) state_d = ST_PRE;
            end
            ST_PRE: begin
                if (cnt == pretrig_l) begin
                    state_d = ST_WAIT_TRIG;
                end else if (in_valid) begin
                    wr_en = 1'b1;
                    if (cnt + ONE_A == pretrig_l) state_d = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                wr_en = in_valid;
                if (level_hit || force_trig) begin
                    accept  = 1'b1;
                    // With no post samples owed, the trigger write itself completes the record.
                    state_d = (in_valid && pretrig_l == MAX_A) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (post_cnt == ONE_P) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            wr_en   = 1'b0;
            accept  = 1'b0;
            arm_go  = 1'b0;
        end
    end

    assign rd_fire = rd_en && (state_q == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr     <= '0;
            cnt        <= '0;
            pretrig_l  <= '0;
            post_cnt   <= '0;
            prev_data  <= '0;
            prev_valid <= 1'b0;
            triggered  <= 1'b0;
            trig_addr  <= '0;
            rd_valid   <= 1'b0;
            rd_loaded  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_valid <= rd_fire;
            if (rd_fire) rd_loaded <= 1'b1;
            if (abort) begin
                triggered <= 1'b0;
            end else if (arm_go) begin
                pretrig_l  <= pretrig;
                wr_ptr     <= '0;
                cnt        <= '0;
                post_cnt   <= '0;
                triggered  <= 1'b0;
                prev_valid <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr     <= wr_ptr + ONE_A;
                    prev_data  <= in_data;
                    prev_valid <= 1'b1;
                end
                if (wr_en && state_q == ST_PRE) cnt <= cnt + ONE_A;
                if (accept) begin
                    triggered <= 1'b1;
                    trig_addr <= wr_ptr;
                    // Post writes still owed; a forced trigger without data also owes the trigger sample.
                    post_cnt  <= in_valid ? {1'b0, MAX_A - pretrig_l}
                                          : {1'b0, MAX_A - pretrig_l} + ONE_P;
                end else if (wr_en && state_q == ST_POST) begin
                    post_cnt <= post_cnt - ONE_P;
                end
            end
        end
    end

    capture_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr),
        .wdata(in_data),
        .re   (rd_fire),
        .raddr(trig_addr - pretrig_l + rd_addr),
        .rdata(ram_q)
    );

    assign state   = state_q;
    assign done    = (state_q == ST_DONE);
    assign rd_data = rd_loaded ? ram_q : '0;

endmodule

// File: tb/tb_mso_capture.sv
// tb/tb_mso_capture.sv - self-checking bench for mso_capture (DEPTH=16)
module tb_mso_capture;

    localparam int DW = 12;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          arm = 1'b0, abort = 1'b0, force_trig = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic          trig_slope = 1'b0;
    logic [AW-1:0] pretrig = '0;
    logic [2:0]    state;
    logic          triggered, done;
    logic [AW-1:0] trig_addr;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    int n_vec = 0;
    int n_bad = 0;

    mso_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .arm(arm), .abort(abort), .force_trig(force_trig),
        .trig_level(trig_level), .trig_slope(trig_slope), .pretrig(pretrig),
        .state(state), .triggered(triggered), .done(done), .trig_addr(trig_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pre; int lvl; int slope; int start; int step;
        int exp_cnt; int exp_taddr; int exp_first;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int p, input int lvl, input int slope);
        pretrig    = AW'(p);
        trig_level = DW'(lvl);
        trig_slope = slope[0];
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
    endtask

    task automatic push(input int d);
        in_valid = 1'b1;
        in_data  = DW'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic read_chk(input string name, input int a, input int exp);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_en = 1'b0;
        check({name, "_valid"}, int'(rd_valid), 1);
        check(name, int'(rd_data), exp & 'hFFF);
    endtask

    initial begin
        int nd, t, p, lvl, slope, exp_cnt;
        int s[60];

        tbl[0] = '{4, 20, 0, 0, 1, 32, 4, 16};
        tbl[1] = '{2, 50, 1, 100, -3, 31, 1, 55};
        tbl[2] = '{0, 5, 0, 5, 7, -1, 0, 0};
        tbl[3] = '{15, 31, 0, 0, 2, 17, 0, 2};

        tick(); tick();
        check("rst_state", int'(state), 0);
        check("rst_done", int'(done), 0);
        check("rst_trig", int'(triggered), 0);
        check("rst_rdv", int'(rd_valid), 0);
        rst_n = 1'b1;
        tick();

        // table-driven ramp captures
        foreach (tbl[v]) begin
            do_arm(tbl[v].pre, tbl[v].lvl, tbl[v].slope);
            nd = -1;
            for (int k = 0; k < 41; k++) begin
                push(tbl[v].start + tbl[v].step * k);
                if (done) begin nd = k + 1; break; end
            end
            check($sformatf("tbl%0d_done_cnt", v), nd, tbl[v].exp_cnt);
            if (tbl[v].exp_cnt > 0) begin
                check($sformatf("tbl%0d_taddr", v), int'(trig_addr), tbl[v].exp_taddr);
                check($sformatf("tbl%0d_trig", v), int'(triggered), 1);
                for (int k = 0; k < 16; k++)
                    read_chk($sformatf("tbl%0d_rd%0d", v, k), k, tbl[v].exp_first + tbl[v].step * k);
            end else begin
                check($sformatf("tbl%0d_notrig", v), int'(triggered), 0);
                check($sformatf("tbl%0d_wait", v), int'(state), 2);
                abort = 1'b1; tick(); abort = 1'b0;
                check($sformatf("tbl%0d_abort", v), int'(state), 0);
            end
        end

        // falling edge, pretrig 0
        do_arm(0, 60, 1);
        push(100); push(100);
        check("fall_early", int'(triggered), 0);
        push(50);
        check("fall_trig", int'(triggered), 1);
        check("fall_taddr", int'(trig_addr), 2);
        for (int j = 0; j < 15; j++) begin
            check("fall_notdone", int'(done), 0);
            push(200 + j);
        end
        check("fall_done", int'(done), 1);
        read_chk("fall_rd0", 0, 50);
        read_chk("fall_rd15", 15, 214);

        // forced trigger: ignored in PRE, accepted in WAIT_TRIG without data
        do_arm(3, 1000, 0);
        force_trig = 1'b1; push(2000); force_trig = 1'b0;
        check("frc_pre_ignored", int'(triggered), 0);
        push(2000); push(2000); push(2000);
        check("frc_no_level", int'(triggered), 0);
        check("frc_wait", int'(state), 2);
        force_trig = 1'b1; tick(); force_trig = 1'b0;
        check("frc_trig", int'(triggered), 1);
        check("frc_taddr", int'(trig_addr), 4);
        check("frc_post", int'(state), 3);
        for (int j = 0; j < 13; j++) begin
            check("frc_notdone", int'(done), 0);
            push(100 + j);
        end
        check("frc_done", int'(done), 1);
        read_chk("frc_rd3", 3, 100);
        read_chk("frc_rd0", 0, 2000);

        // gappy input, level and force in the same cycle
        do_arm(5, 500, 0);
        for (int k = 0; k < 16; k++) begin
            if (k == 5) force_trig = 1'b1;
            push(400 + 20 * k);
            force_trig = 1'b0;
            if (k == 5) check("gap_taddr", int'(trig_addr), 5);
            if (k == 14) check("gap_notdone", int'(done), 0);
            tick(); tick();
        end
        check("gap_done", int'(done), 1);
        for (int k = 0; k < 16; k++)
            read_chk($sformatf("gap_rd%0d", k), k, 400 + 20 * k);

        // abort in POST, then re-arm with maximum pretrig
        do_arm(0, 100, 0);
        push(50); push(150); push(1); push(2); push(3);
        check("abt_post", int'(state), 3);
        abort = 1'b1; arm = 1'b1; tick(); abort = 1'b0; arm = 1'b0;
        check("abt_idle", int'(state), 0);
        check("abt_done", int'(done), 0);
        check("abt_trig", int'(triggered), 0);
        push(7);
        check("abt_stays_idle", int'(state), 0);
        do_arm(15, 100, 0);
        for (int k = 0; k < 15; k++) push(k);
        check("max_wait", int'(state), 2);
        push(200);
        check("max_done", int'(done), 1);
        check("max_taddr", int'(trig_addr), 15);
        read_chk("max_rd15", 15, 200);
        read_chk("max_rd0", 0, 0);
        read_chk("max_rd14", 14, 14);

        // asynchronous reset while waiting for a trigger
        do_arm(2, 4000, 0);
        push(1); push(2); push(3);
        check("rst_pre_wait", int'(state), 2);
        rst_n = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_trig", int'(triggered), 0);
        check("arst_done", int'(done), 0);
        check("arst_taddr", int'(trig_addr), 0);
        check("arst_rdata", int'(rd_data), 0);
        check("arst_rdv", int'(rd_valid), 0);
        rst_n = 1'b1;
        tick();
        rd_en = 1'b1; rd_addr = 4'd3; tick(); rd_en = 1'b0;
        check("idle_rdv", int'(rd_valid), 0);
        check("idle_rdata", int'(rd_data), 0);

        // randomized captures against a sequence-level model
        for (int it = 0; it < 10; it++) begin
            p     = $urandom_range(0, 15);
            lvl   = $urandom_range(200, 3800);
            slope = $urandom_range(0, 1);
            foreach (s[i]) s[i] = $urandom_range(0, 4095);
            t = -1;
            for (int i = (p > 0 ? p : 1); i < 60 && t < 0; i++) begin
                if (slope == 0 ? (s[i-1] < lvl && s[i] >= lvl) : (s[i-1] >= lvl && s[i] < lvl))
                    t = i;
            end
            exp_cnt = (t >= 0 && t + 16 - p <= 60) ? t + 16 - p : -1;
            do_arm(p, lvl, slope);
            nd = -1;
            for (int i = 0; i < 60; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                push(s[i]);
                if (done) begin nd = i + 1; break; end
            end
            check($sformatf("rnd%0d_done_cnt", it), nd, exp_cnt);
            if (exp_cnt > 0 && nd == exp_cnt) begin
                check($sformatf("rnd%0d_taddr", it), int'(trig_addr), t % 16);
                for (int k = 0; k < 16; k++)
                    read_chk($sformatf("rnd%0d_rd%0d", it, k), k, s[t - p + k]);
            end else begin
                abort = 1'b1; tick(); abort = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
